// File: rtl/pll_lock_supervisor_pkg.sv
// pll_lock_supervisor_pkg: state encodings and default parameters for the PLL lock supervisor
package pll_lock_supervisor_pkg;
  localparam logic [1:0] ST_WAIT    = 2'b00;
  localparam logic [1:0] ST_FILTER  = 2'b01;
  localparam logic [1:0] ST_HOLDOFF = 2'b10;
  localparam logic [1:0] ST_RUN     = 2'b11;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_FILTER_CYCLES  = 16;
  localparam int DEF_HOLDOFF_CYCLES = 4096;
  localparam int DEF_LOSS_CNT_W     = 8;
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: N-stage synchronizer for a single asynchronous status bit
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: filters PLL lock into a clean downstream reset and tracks lock losses
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int LOSS_CNT_W     = DEF_LOSS_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  clear_flag,
  output logic                  sys_reset,
  output logic                  sys_ready,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic                  loss_flag
);
  localparam int CW = $clog2((FILTER_CYCLES > HOLDOFF_CYCLES ? FILTER_CYCLES : HOLDOFF_CYCLES) + 1);
  // FILTER leaves on the sample that would bring the count to FILTER_CYCLES
  localparam logic [CW-1:0] F_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLDOFF_CYCLES);
  logic          lock_s;
  logic          loss;
  logic [1:0]    nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pll_lock),
    .q    (lock_s)
  );
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    loss      = 1'b0;
    if (!lock_s) begin
      nxt_state = ST_WAIT;
      nxt_cnt   = '0;
      loss      = state == ST_RUN;
    end else if (state == ST_WAIT) begin
      nxt_state = ST_FILTER;
      nxt_cnt   = CW'(1);
    end else if (state == ST_FILTER) begin
      nxt_state = cnt >= F_LAST ? ST_HOLDOFF : ST_FILTER;
      nxt_cnt   = cnt >= F_LAST ? CW'(1) : cnt + 1'b1;
    end else if (state == ST_HOLDOFF) begin
      nxt_state = cnt >= H_LAST ? ST_RUN : ST_HOLDOFF;
      nxt_cnt   = cnt >= H_LAST ? '0 : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_WAIT;
      cnt        <= '0;
      sys_reset  <= 1'b1;
      sys_ready  <= 1'b0;
      loss_count <= '0;
      loss_flag  <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      sys_reset <= nxt_state != ST_RUN;
      sys_ready <= nxt_state == ST_RUN;
      if (loss && !(&loss_count)) loss_count <= loss_count + 1'b1;
      loss_flag <= loss | (loss_flag & ~clear_flag);
    end
  end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed and randomized checks against a run-length reference model
module tb_pll_lock_supervisor;
  localparam int S = 2, F = 4, H = 8, W = 2;
  logic clk = 1'b0, reset = 1'b0, pll_lock = 1'b0, clear_flag = 1'b0;
  logic sys_reset, sys_ready, loss_flag;
  logic [1:0] state;
  logic [W-1:0] loss_count;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  pll_lock_supervisor #(
    .SYNC_STAGES(S), .FILTER_CYCLES(F), .HOLDOFF_CYCLES(H), .LOSS_CNT_W(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .clear_flag(clear_flag),
    .sys_reset (sys_reset),
    .sys_ready (sys_ready),
    .state     (state),
    .loss_count(loss_count),
    .loss_flag (loss_flag)
  );
  // Model: lock_s is the raw sample S edges ago; state follows the length of the current high run
  bit hist[$];
  int run = 0, m_loss = 0;
  bit m_flag = 1'b0, m_ls, m_lost;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      run = 0;
      m_loss = 0;
      m_flag = 1'b0;
    end else begin
      m_ls = hist.size() == S ? hist[0] : 1'b0;
      m_lost = !m_ls && run >= F + H;
      run = m_ls ? (run < F + H ? run + 1 : run) : 0;
      if (m_lost && m_loss < (1 << W) - 1) m_loss++;
      m_flag = m_lost || (m_flag && !clear_flag);
      hist.push_back(pll_lock);
      if (hist.size() > S) void'(hist.pop_front());
    end
  end
  function automatic logic [1:0] exp_state(int r);
    return r == 0 ? 2'd0 : r < F ? 2'd1 : r < F + H ? 2'd2 : 2'd3;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all(input string t);
    logic [1:0] es;
    es = exp_state(run);
    check({t, "_state"}, 32'(state), 32'(es));
    check({t, "_sys_reset"}, 32'(sys_reset), 32'(es != 2'd3));
    check({t, "_sys_ready"}, 32'(sys_ready), 32'(es == 2'd3));
    check({t, "_loss_count"}, 32'(loss_count), 32'(m_loss));
    check({t, "_loss_flag"}, 32'(loss_flag), 32'(m_flag));
  endtask
  task automatic tick(input string t);
    @(negedge clk);
    check_all(t);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic lose_lock(input bit clr);
    pll_lock = 1'b1;
    repeat (14) tick("relock");
    pll_lock = 1'b0;
    repeat (2) tick("drop");
    clear_flag = clr;
    tick("loss");
    clear_flag = 1'b0;
  endtask
  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all("rst");
    // Clean lock
    pll_lock = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick("s1");
      if (e == 13) check("s1_rst_e13", 32'(sys_reset), 32'd1);
      if (e == 14) check("s1_rst_e14", 32'(sys_reset), 32'd0);
    end
    check("s1_state", 32'(state), 32'd3);
    check("s1_loss", 32'(loss_count), 32'd0);
    // Glitch during FILTER
    do_reset();
    pll_lock = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick("s2");
      if (e == 3) pll_lock = 1'b0;
      if (e == 5) pll_lock = 1'b1;
      if (e == 6) check("s2_wait", 32'(state), 32'd0);
      if (e == 18) check("s2_rst_e18", 32'(sys_reset), 32'd1);
      if (e == 19) check("s2_rst_e19", 32'(sys_reset), 32'd0);
    end
    check("s2_loss", 32'(loss_count), 32'd0);
    // Loss in RUN
    pll_lock = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick("s3");
      if (e == 2) check("s3_rst_e2", 32'(sys_reset), 32'd0);
    end
    check("s3_rst_e3", 32'(sys_reset), 32'd1);
    check("s3_count", 32'(loss_count), 32'd1);
    check("s3_flag", 32'(loss_flag), 32'd1);
    check("s3_state", 32'(state), 32'd0);
    // Saturation and flag priority
    repeat (3) lose_lock(1'b0);
    check("s4_sat", 32'(loss_count), 32'd3);
    lose_lock(1'b1);
    check("s4_set_wins", 32'(loss_flag), 32'd1);
    clear_flag = 1'b1;
    tick("s4_clr");
    clear_flag = 1'b0;
    check("s4_cleared", 32'(loss_flag), 32'd0);
    check("s4_count_kept", 32'(loss_count), 32'd3);
    // Reset mid-HOLDOFF
    do_reset();
    pll_lock = 1'b1;
    repeat (10) tick("s5_pre");
    check("s5_holdoff", 32'(state), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("s5_async_rst", 32'(sys_reset), 32'd1);
    check("s5_async_rdy", 32'(sys_ready), 32'd0);
    check("s5_async_state", 32'(state), 32'd0);
    check("s5_async_cnt", 32'(loss_count), 32'd0);
    check("s5_async_flag", 32'(loss_flag), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick("s5");
      if (e == 13) check("s5_rst_e13", 32'(sys_reset), 32'd1);
    end
    check("s5_rst_e14", 32'(sys_reset), 32'd0);
    // Async lock jitter with runs long enough to reach RUN sometimes
    begin
      int left = 0;
      for (int c = 0; c < 1000; c++) begin
        tick("jit");
        clear_flag = $urandom_range(0, 15) == 0;
        if (left == 0) begin
          left = pll_lock ? $urandom_range(1, 4) : $urandom_range(1, 25);
          #($urandom_range(1, 3)) pll_lock = ~pll_lock;
        end else left--;
      end
      clear_flag = 1'b0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
